pls_bus_arbiter: RTL and testbench

//  Shares one OCP-style PLS master bus between NUM_REQ vector-unit requesters.

---
 rtl/pls_bus_pkg.sv | 31 +++
 rtl/pls_arb_id_fifo.sv | 50 +++++
 rtl/pls_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_pls_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pls_bus_pkg.sv
// Shared types and helpers for the PLS bus arbiter: command/response encodings,
// arbiter state and requester-ID sizing.
package pls_bus_pkg;

   localparam int unsigned CMD_W  = 3;
   localparam int unsigned RESP_W = 2;

   typedef enum logic [2:0] {
      CMD_IDLE = 3'd0,
      CMD_WR   = 3'd1,
      CMD_RD   = 3'd2
   } pls_cmd_t;

   typedef enum logic [1:0] {
      RESP_NULL = 2'd0,
      RESP_DVA  = 2'd1,
      RESP_FAIL = 2'd2,
      RESP_ERR  = 2'd3
   } pls_resp_t;

   typedef enum logic {
      ARB_FREE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   // Requester-ID width; never below one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pls_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding reads. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module pls_arb_id_fifo
   import pls_bus_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (reset_n && push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      head  = mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: rtl/pls_bus_arbiter.sv
// Round-robin arbiter sharing one PLS master bus between NUM_REQ requesters.
// Command path is combinational; read responses are routed in issue order.
module pls_bus_arbiter
   import pls_bus_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ*CMD_W-1:0]  req_MCmd,
   input  logic [NUM_REQ*ADDR_W-1:0] req_MAddr,
   input  logic [NUM_REQ*DATA_W-1:0] req_MData,
   input  logic [NUM_REQ-1:0]        req_MRespAccept,
   output logic [NUM_REQ-1:0]        req_SCmdAccept,
   output logic [NUM_REQ*RESP_W-1:0] req_SResp,
   output logic [DATA_W-1:0]         req_SData,
   output logic [CMD_W-1:0]          bus_MCmd,
   output logic [ADDR_W-1:0]         bus_MAddr,
   output logic [DATA_W-1:0]         bus_MData,
   output logic                      bus_MRespAccept,
   input  logic                      bus_SCmdAccept,
   input  logic [RESP_W-1:0]         bus_SResp,
   input  logic [DATA_W-1:0]         bus_SData
);

   localparam int unsigned ID_W = id_width(NUM_REQ);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   rr_ptr_nxt;
   logic [ID_W-1:0]   lock_id;
   logic [ID_W-1:0]   lock_id_nxt;

   logic [NUM_REQ-1:0] req_vec;
   logic [ID_W-1:0]    win_free;
   logic [ID_W-1:0]    cand;
   logic               found;
   int unsigned        idx;

   logic [ID_W-1:0]   win;
   logic              present;
   logic              accept;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ID_W-1:0]   head;
   logic              proto_err;

   always_comb begin
      req_vec = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         req_vec[i] = (req_MCmd[i*CMD_W +: CMD_W] != CMD_IDLE);
   end

   // First requesting slot at or after rr_ptr, cyclically.
   always_comb begin
      win_free = '0;
      cand     = '0;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx  = (32'(rr_ptr) + k) % NUM_REQ;
         cand = ID_W'(idx);
         if (!found && req_vec[cand]) begin
            found    = 1'b1;
            win_free = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ARB_FREE;
         rr_ptr  <= '0;
         lock_id <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         lock_id <= lock_id_nxt;
      end
   end

   // Command phase: grant mux, lock on unaccepted command, advance on accept.
   always_comb begin
      state_nxt      = state;
      rr_ptr_nxt     = rr_ptr;
      lock_id_nxt    = lock_id;
      bus_MCmd       = '0;
      bus_MAddr      = '0;
      bus_MData      = '0;
      req_SCmdAccept = '0;

      win     = (state == ARB_LOCKED) ? lock_id : win_free;
      // A full ID FIFO stalls every command, writes included, to keep ordering trivial.
      present = req_vec[win] && !fifo_full;
      accept  = present && bus_SCmdAccept;
      push    = accept && (req_MCmd[32'(win)*CMD_W +: CMD_W] == CMD_RD);

      if (present) begin
         bus_MCmd            = req_MCmd[32'(win)*CMD_W +: CMD_W];
         bus_MAddr           = req_MAddr[32'(win)*ADDR_W +: ADDR_W];
         bus_MData           = req_MData[32'(win)*DATA_W +: DATA_W];
         req_SCmdAccept[win] = bus_SCmdAccept;
      end

      case (state)
         ARB_FREE: begin
            if (present && !bus_SCmdAccept) begin
               state_nxt   = ARB_LOCKED;
               lock_id_nxt = win;
            end
         end
         ARB_LOCKED: begin
            if (!present && !fifo_full)
               state_nxt = ARB_FREE;
         end
         default: state_nxt = ARB_FREE;
      endcase

      if (accept) begin
         state_nxt  = ARB_FREE;
         rr_ptr_nxt = ID_W'((32'(win) + 32'd1) % NUM_REQ);
      end
   end

   // Response phase: only the FIFO head sees the bus response.
   always_comb begin
      req_SResp       = '0;
      bus_MRespAccept = 1'b0;
      req_SData       = bus_SData;
      if (!fifo_empty) begin
         req_SResp[32'(head)*RESP_W +: RESP_W] = bus_SResp;
         bus_MRespAccept                       = req_MRespAccept[head];
      end
      pop = bus_MRespAccept && (bus_SResp != RESP_NULL);
   end

   pls_arb_id_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (win),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (head)
   );

   // A response with nothing outstanding is dropped; the flag latches until reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         proto_err <= 1'b0;
      end else begin
         if (fifo_empty && (bus_SResp != RESP_NULL))
            proto_err <= 1'b1;
         assert (!proto_err);
      end
   end

endmodule

// File: tb/tb_pls_bus_arbiter.sv
// Bench for pls_bus_arbiter: directed scenarios then randomized traffic, all
// compared against a queue-based model of grant order and read routing.
module tb_pls_bus_arbiter;
   import pls_bus_pkg::*;

   localparam int N  = 4;
   localparam int MO = 4;

   logic            clk;
   logic            reset_n;
   logic [N*3-1:0]  req_MCmd;
   logic [N*32-1:0] req_MAddr;
   logic [N*32-1:0] req_MData;
   logic [N-1:0]    req_MRespAccept;
   logic [N-1:0]    req_SCmdAccept;
   logic [N*2-1:0]  req_SResp;
   logic [31:0]     req_SData;
   logic [2:0]      bus_MCmd;
   logic [31:0]     bus_MAddr;
   logic [31:0]     bus_MData;
   logic            bus_MRespAccept;
   logic            bus_SCmdAccept;
   logic [1:0]      bus_SResp;
   logic [31:0]     bus_SData;

   pls_bus_arbiter #(
      .NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(MO)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_MCmd        (req_MCmd),
      .req_MAddr       (req_MAddr),
      .req_MData       (req_MData),
      .req_MRespAccept (req_MRespAccept),
      .req_SCmdAccept  (req_SCmdAccept),
      .req_SResp       (req_SResp),
      .req_SData       (req_SData),
      .bus_MCmd        (bus_MCmd),
      .bus_MAddr       (bus_MAddr),
      .bus_MData       (bus_MData),
      .bus_MRespAccept (bus_MRespAccept),
      .bus_SCmdAccept  (bus_SCmdAccept),
      .bus_SResp       (bus_SResp),
      .bus_SData       (bus_SData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester-side stimulus: a command stays up until it is accepted.
   logic [2:0]  cmd   [N];
   logic [31:0] addr  [N];
   logic [31:0] wdata [N];

   // Reference model: issue-ordered queue of read owners, next-priority slot, held grant.
   int q[$];
   int rr;
   int held;
   int e_win;
   bit e_present;
   bit e_accept;
   bit e_pop;

   int n_chk;
   int n_fail;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int pick();
      if (held >= 0) return held;
      for (int k = 0; k < N; k++) begin
         if (cmd[(rr + k) % N] != 3'd0) return (rr + k) % N;
      end
      return -1;
   endfunction

   // Drive inputs, let them settle, and compare against the model.
   task automatic settle();
      logic [63:0] er;
      for (int i = 0; i < N; i++) begin
         req_MCmd[i*3 +: 3]   = cmd[i];
         req_MAddr[i*32 +: 32] = addr[i];
         req_MData[i*32 +: 32] = wdata[i];
      end
      #1;
      e_win     = pick();
      e_present = (e_win >= 0) && (q.size() < MO);
      e_accept  = e_present && bus_SCmdAccept;
      e_pop     = (q.size() > 0) && (bus_SResp != 2'd0) && req_MRespAccept[q[0]];
      if (reset_n) begin
         chk("bus_MCmd", 64'(bus_MCmd), e_present ? 64'(cmd[e_win]) : 64'd0);
         chk("req_SCmdAccept", 64'(req_SCmdAccept), e_accept ? (64'd1 << e_win) : 64'd0);
         if (e_present) begin
            chk("bus_MAddr", 64'(bus_MAddr), 64'(addr[e_win]));
            chk("bus_MData", 64'(bus_MData), 64'(wdata[e_win]));
         end
         er = (q.size() > 0) ? (64'(bus_SResp) << (2 * q[0])) : 64'd0;
         chk("req_SResp", 64'(req_SResp), er);
         chk("bus_MRespAccept", 64'(bus_MRespAccept),
             (q.size() > 0) ? 64'(req_MRespAccept[q[0]]) : 64'd0);
         if (q.size() > 0)
            chk("req_SData", 64'(req_SData), 64'(bus_SData));
      end
   endtask

   // Advance one clock: update the model at the edge, retire stimulus after it.
   task automatic tick();
      @(posedge clk);
      if (!reset_n) begin
         q.delete();
         rr   = 0;
         held = -1;
      end else begin
         if (e_pop) void'(q.pop_front());
         if (e_accept) begin
            if (cmd[e_win] == 3'(CMD_RD)) q.push_back(e_win);
            rr   = (e_win + 1) % N;
            held = -1;
         end else if (e_present) begin
            held = e_win;
         end
      end
      @(negedge clk);
      if (!reset_n) begin
         for (int i = 0; i < N; i++) cmd[i] = 3'd0;
         bus_SResp = 2'd0;
      end else begin
         if (e_accept) cmd[e_win] = 3'd0;
         if (e_pop) bus_SResp = 2'd0;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      settle();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic rand_stim();
      for (int i = 0; i < N; i++) begin
         if (cmd[i] == 3'd0 && $urandom_range(0, 99) < 40) begin
            cmd[i]   = 3'($urandom_range(1, 2));
            addr[i]  = $urandom;
            wdata[i] = $urandom;
         end
         req_MRespAccept[i] = ($urandom_range(0, 99) < 70);
      end
      bus_SCmdAccept = ($urandom_range(0, 99) < 60);
      if (bus_SResp == 2'd0 && q.size() > 0 && $urandom_range(0, 1) == 1) begin
         bus_SResp = 2'($urandom_range(1, 3));
         bus_SData = $urandom;
      end
      reset_n = ($urandom_range(0, 199) != 0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rr     = 0;
      held   = -1;
      for (int i = 0; i < N; i++) begin
         cmd[i]   = 3'd0;
         addr[i]  = 32'd0;
         wdata[i] = 32'd0;
      end
      req_MRespAccept = '1;
      bus_SCmdAccept  = 1'b0;
      bus_SResp       = 2'd0;
      bus_SData       = 32'd0;
      reset_n         = 1'b0;
      settle(); tick();
      do_reset();

      // Post-reset idle outputs
      settle();
      chk("rst_mcmd", 64'(bus_MCmd), 64'd0);
      chk("rst_sresp", 64'(req_SResp), 64'd0);
      chk("rst_mrespacc", 64'(bus_MRespAccept), 64'd0);
      chk("rst_cmdacc", 64'(req_SCmdAccept), 64'd0);
      tick();

      // Single read, same-cycle accept, then DVA routed back
      cmd[0] = 3'(CMD_RD); addr[0] = 32'h10; wdata[0] = 32'h0;
      bus_SCmdAccept = 1'b1;
      settle();
      chk("t1_addr", 64'(bus_MAddr), 64'h10);
      chk("t1_acc", 64'(req_SCmdAccept), 64'h1);
      tick();
      bus_SResp = 2'(RESP_DVA); bus_SData = 32'hAB;
      settle();
      chk("t1_resp", 64'(req_SResp), 64'h01);
      chk("t1_data", 64'(req_SData), 64'hAB);
      chk("t1_racc", 64'(bus_MRespAccept), 64'h1);
      tick();

      // All four reading every cycle: grants 0,1,2,3,0 with in-order routing
      do_reset();
      bus_SCmdAccept = 1'b1;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++) begin
            if (cmd[i] == 3'd0) begin
               cmd[i] = 3'(CMD_RD); addr[i] = 32'(16 * k + i); wdata[i] = 32'd0;
            end
         end
         if (k > 0) begin
            bus_SResp = 2'(RESP_DVA); bus_SData = 32'(k);
         end
         settle();
         chk("t2_grant", 64'(req_SCmdAccept), 64'd1 << (k % N));
         if (k > 0) chk("t2_route", 64'(req_SResp), 64'd1 << (2 * ((k - 1) % N)));
         tick();
      end

      // Unaccepted write keeps the grant while others (including higher priority) wait
      do_reset();
      bus_SCmdAccept = 1'b0;
      cmd[1] = 3'(CMD_WR); addr[1] = 32'h100; wdata[1] = 32'h1;
      settle();
      chk("t3_noacc", 64'(req_SCmdAccept), 64'h0);
      chk("t3_addr", 64'(bus_MAddr), 64'h100);
      tick();
      cmd[2] = 3'(CMD_WR); addr[2] = 32'h200; wdata[2] = 32'h2;
      cmd[0] = 3'(CMD_RD); addr[0] = 32'h300; wdata[0] = 32'h3;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("t3_lock", 64'(bus_MAddr), 64'h100);
         chk("t3_lock_acc", 64'(req_SCmdAccept), 64'h0);
         tick();
      end
      bus_SCmdAccept = 1'b1;
      settle(); chk("t3_acc1", 64'(req_SCmdAccept), 64'h2); tick();
      settle(); chk("t3_acc2", 64'(req_SCmdAccept), 64'h4); tick();
      settle(); chk("t3_acc0", 64'(req_SCmdAccept), 64'h1); tick();

      // FIFO full blocks issue until a response pops
      do_reset();
      bus_SCmdAccept = 1'b1;
      for (int i = 0; i < N; i++) begin
         cmd[i] = 3'(CMD_RD); addr[i] = 32'(32'h40 + i); wdata[i] = 32'd0;
      end
      for (int k = 0; k < N; k++) begin
         settle(); tick();
      end
      cmd[0] = 3'(CMD_RD); addr[0] = 32'h50;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("t4_block", 64'(bus_MCmd), 64'h0);
         chk("t4_block_acc", 64'(req_SCmdAccept), 64'h0);
         tick();
      end
      bus_SResp = 2'(RESP_DVA); bus_SData = 32'h11;
      settle();
      chk("t4_full_pop_cmd", 64'(bus_MCmd), 64'h0);
      chk("t4_full_pop_racc", 64'(bus_MRespAccept), 64'h1);
      tick();
      settle();
      chk("t4_issue", 64'(bus_MCmd), 64'(CMD_RD));
      chk("t4_issue_acc", 64'(req_SCmdAccept), 64'h1);
      tick();

      // Head requester refuses the response for two cycles
      bus_SCmdAccept  = 1'b0;
      req_MRespAccept = 4'b1101;
      bus_SResp = 2'(RESP_DVA); bus_SData = 32'h22;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("t5_hold", 64'(bus_MRespAccept), 64'h0);
         chk("t5_route", 64'(req_SResp), 64'h04);
         tick();
      end
      req_MRespAccept = '1;
      settle(); chk("t5_pop", 64'(bus_MRespAccept), 64'h1); tick();
      bus_SResp = 2'(RESP_ERR); bus_SData = 32'h33;
      settle(); chk("t5_next", 64'(req_SResp), 64'h30); tick();

      // Reset with reads outstanding and a response in flight
      reset_n   = 1'b0;
      bus_SResp = 2'(RESP_DVA);
      settle(); tick();
      reset_n = 1'b1;
      settle();
      chk("t6_mcmd", 64'(bus_MCmd), 64'h0);
      chk("t6_sresp", 64'(req_SResp), 64'h0);
      chk("t6_racc", 64'(bus_MRespAccept), 64'h0);
      tick();
      bus_SCmdAccept = 1'b1;
      for (int i = 0; i < N; i++) begin
         cmd[i] = 3'(CMD_RD); addr[i] = 32'(32'h80 + i);
      end
      settle(); chk("t6_rr", 64'(req_SCmdAccept), 64'h1); tick();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rand_stim();
         settle();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
